// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-slave slice.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_state_e;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b0010000;
  localparam int BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = '1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA synchronizer, optional 3-sample majority filter (I2C_SLAVE_GLITCH_FILTER_EN)
// and SCL edge / START / STOP detection.
module i2c_line_cond
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_val
);

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic       scl_c, sda_c;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl_c;
    sda_prev_d = sda_c;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
    scl_filt_d = maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
    sda_filt_d = maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  // START/STOP need SCL high on both samples so an SCL edge never masquerades as one.
  assign scl_rise  =  scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c &  scl_prev_q;
  assign start_det =  scl_c &  scl_prev_q &  sda_prev_q & ~sda_c;
  assign stop_det  =  scl_c &  scl_prev_q & ~sda_prev_q &  sda_c;
  assign sda_val   =  sda_c;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing REG_DEPTH 8-bit registers behind an auto-incrementing pointer.
// Optional input glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         REG_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output i2c_state_e dbg_state
);

  localparam int PTR_W = $clog2(REG_DEPTH);

  logic scl_rise, scl_fall, start_det, stop_det, sda_val;

  i2c_line_cond u_line_cond (
    .clk       (clk),
    .resetN    (resetN),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_val   (sda_val)
  );

  i2c_state_e             state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   rw_q, rw_d, nack_q, nack_d;
  logic                   sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0]             wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [7:0]             regs_q [REG_DEPTH];
  logic [7:0]             regs_d [REG_DEPTH];
  logic [7:0]             rx_byte;
  logic [BIT_CNT_W-1:0]   tx_idx;

  assign rx_byte = {shift_q, sda_val};
  assign tx_idx  = BIT_LAST - bit_cnt_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              if (state_q == ST_ADDR) begin
                rw_d    = sda_val;
                state_d = (shift_q == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IDLE;
              end else if (state_q == ST_PTR) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_strobe_d   = 1'b1;
                wr_addr_d     = 8'(ptr_q);
                wr_data_d     = rx_byte;
                ptr_d         = ptr_q + 1'b1;
                state_d       = ST_WDATA_ACK;
              end
            end
          end
        end
        // bit_cnt marks whether the 9th rise has been seen: first fall drives ACK, second ends the slot.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == '0) begin
              sda_oe_d = 1'b1;
            end else begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d  = ST_RDATA;
                sda_oe_d = ~regs_q[ptr_q][7];
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              ptr_d   = ptr_q + 1'b1;
              state_d = ST_RDATA_ACK;
            end
          end else if (scl_fall && bit_cnt_q != '0) begin
            sda_oe_d = ~regs_q[ptr_q][tx_idx];
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 'd1;
            nack_d    = sda_val;
          end else if (scl_fall) begin
            if (bit_cnt_q == '0) begin
              sda_oe_d = 1'b0;
            end else begin
              bit_cnt_d = '0;
              if (nack_q) begin
                state_d  = ST_IDLE;
                sda_oe_d = 1'b0;
              end else begin
                state_d  = ST_RDATA;
                sda_oe_d = ~regs_q[ptr_q][7];
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      regs_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  // wr_addr/wr_data are only meaningful in the cycle wr_strobe is high.
  assign sda_oe    = sda_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master with open-drain SDA.
module tb_i2c_slave_regs;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_strobe, busy;
  logic [7:0] wr_addr, wr_data;
  i2c_state_e dbg_state;

  int         checks = 0;
  int         errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [7:0]  rd_q[$];
  int          ack_miss = 0;
  int          oe_viol = 0;
  logic        oe_seen = 1'b0;
  logic        scl_prev_s = 1'b1;
  logic        oe_prev_s = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(7'h10), .REG_DEPTH(16)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (wr_strobe) got_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1'b1;
    if (resetN && scl_m && scl_prev_s && (sda_oe !== oe_prev_s)) oe_viol++;
    scl_prev_s = scl_m;
    oe_prev_s  = sda_oe;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; wait_clks(4);
    scl_m = 1'b1; wait_clks(8);
    sda_m = 1'b0; wait_clks(8);
    scl_m = 1'b0; wait_clks(4);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wait_clks(4);
    scl_m = 1'b1; wait_clks(8);
    sda_m = 1'b1; wait_clks(8);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clks(4);
    scl_m = 1'b1; wait_clks(8);
    scl_m = 1'b0; wait_clks(4);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clks(4);
    scl_m = 1'b1; wait_clks(4);
    b = sda_line; wait_clks(4);
    scl_m = 1'b0; wait_clks(4);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  // Sets the pointer, repeated START, reads n bytes (NACK on the last); leaves bus without STOP.
  task automatic read_regs(input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] d;
    rd_q.delete();
    ack_miss = 0;
    bus_start;
    send_byte(8'h20, ack); if (ack) ack_miss++;
    send_byte(ptr, ack);   if (ack) ack_miss++;
    bus_start;
    send_byte(8'h21, ack); if (ack) ack_miss++;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      rd_q.push_back(d);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    resetN = 1'b0;
    wait_clks(3);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b required 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe: got %b required 0", wr_strobe); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h required 00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h required 00", wr_data); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
    resetN = 1'b1;
    wait_clks(6);
    checks++; if (busy !== 1'b0 || sda_oe !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got busy=%b oe=%b required 0/0", busy, sda_oe); end
  endtask

  task automatic test_write;
    logic       ack;
    logic [15:0] exp_v, got_v;
    got_q.delete();
    exp_q = '{16'h02A5, 16'h033C};
    bus_start;
    send_byte(8'h20, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b required 0", ack); end
    send_byte(8'h02, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_ptr_ack: got %b required 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_mid: got %b required 1", busy); end
    send_byte(8'hA5, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_data0_ack: got %b required 0", ack); end
    send_byte(8'h3C, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_data1_ack: got %b required 0", ack); end
    bus_stop;
    wait_clks(4);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL write_strobe_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      checks++; if (got_v !== exp_v) begin errors++; $display("FAIL write_strobe_data: got addr/data %h required %h", got_v, exp_v); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b required 0", busy); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL write_state_after_stop: got %0d required %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_read;
    got_q.delete();
    read_regs(8'h02, 2);
    checks++; if (ack_miss !== 0) begin errors++; $display("FAIL read_acks: got %0d missing required 0", ack_miss); end
    checks++; if (rd_q[0] !== 8'hA5) begin errors++; $display("FAIL read_byte0: got %h required a5", rd_q[0]); end
    checks++; if (rd_q[1] !== 8'h3C) begin errors++; $display("FAIL read_byte1: got %h required 3c", rd_q[1]); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL read_idle_after_nack: got %0d required %0d", dbg_state, ST_IDLE); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL read_release_after_nack: got %b required 0", sda_oe); end
    bus_stop;
    wait_clks(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_stop: got %b required 0", busy); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL read_no_strobe: got %0d strobes required 0", got_q.size()); end
  endtask

  task automatic test_wrong_addr;
    logic ack;
    got_q.delete();
    oe_seen = 1'b0;
    bus_start;
    send_byte(8'h22, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wrong_addr_nack: got %b required 1", ack); end
    send_byte(8'h55, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wrong_addr_data_nack: got %b required 1", ack); end
    bus_stop;
    wait_clks(4);
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL wrong_addr_oe: got %b required 0", oe_seen); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL wrong_addr_strobe: got %0d strobes required 0", got_q.size()); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL wrong_addr_state: got %0d required %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_wrap;
    logic        ack;
    int          nacks;
    logic [15:0] exp_v, got_v;
    got_q.delete();
    exp_q = '{16'h0F11, 16'h0022};
    nacks = 0;
    bus_start;
    send_byte(8'h20, ack); if (ack) nacks++;
    send_byte(8'h0F, ack); if (ack) nacks++;
    send_byte(8'h11, ack); if (ack) nacks++;
    send_byte(8'h22, ack); if (ack) nacks++;
    bus_stop;
    wait_clks(4);
    checks++; if (nacks != 0) begin errors++; $display("FAIL wrap_acks: got %0d missing required 0", nacks); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_strobe_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
      checks++; if (got_v !== exp_v) begin errors++; $display("FAIL wrap_strobe_data: got addr/data %h required %h", got_v, exp_v); end
    end
    read_regs(8'h0F, 2);
    bus_stop;
    checks++; if (rd_q[0] !== 8'h11) begin errors++; $display("FAIL wrap_read_reg15: got %h required 11", rd_q[0]); end
    checks++; if (rd_q[1] !== 8'h22) begin errors++; $display("FAIL wrap_read_reg0: got %h required 22", rd_q[1]); end
  endtask

  task automatic test_stop_mid;
    logic ack;
    got_q.delete();
    bus_start;
    send_byte(8'h20, ack);
    send_byte(8'h05, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus_stop;
    wait_clks(4);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL stop_mid_strobe: got %0d strobes required 0", got_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_mid_busy: got %b required 0", busy); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL stop_mid_oe: got %b required 0", sda_oe); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL stop_mid_state: got %0d required %0d", dbg_state, ST_IDLE); end
    read_regs(8'h05, 1);
    bus_stop;
    checks++; if (rd_q[0] !== 8'h00) begin errors++; $display("FAIL stop_mid_reg5: got %h required 00", rd_q[0]); end
  endtask

  task automatic test_reset_mid_read;
    logic ack, b;
    int   nonzero;
    got_q.delete();
    bus_start;
    send_byte(8'h20, ack);
    send_byte(8'h02, ack);
    bus_start;
    send_byte(8'h21, ack);
    read_bit(b);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL rst_read_msb: got %b required 1", b); end
    wait_clks(2);
    // bit 6 of 0xA5 is 0, so the slave is pulling SDA low here
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_read_driving: got %b required 1", sda_oe); end
    resetN = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_oe_release: got %b required 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    wait_clks(3);
    resetN = 1'b1;
    wait_clks(2);
    send_byte(8'h20, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_ignore_until_start: got ack %b required 1", ack); end
    bus_stop;
    wait_clks(4);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_no_strobe: got %0d strobes required 0", got_q.size()); end
    read_regs(8'h0F, 5);
    bus_stop;
    nonzero = 0;
    foreach (rd_q[i]) if (rd_q[i] !== 8'h00) nonzero++;
    checks++; if (ack_miss !== 0) begin errors++; $display("FAIL rst_readback_acks: got %0d missing required 0", ack_miss); end
    checks++; if (nonzero != 0) begin errors++; $display("FAIL rst_regs_cleared: got %0d nonzero of regs 15,0,1,2,3 required 0", nonzero); end
  endtask

  task automatic test_sda_timing;
    checks++; if (oe_viol != 0) begin errors++; $display("FAIL sda_oe_while_scl_high: got %0d changes required 0", oe_viol); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset;
    test_write;
    test_read;
    test_wrong_addr;
    test_wrap;
    test_stop_mid;
    test_reset_mid_read;
    test_sda_timing;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
